// File: rtl/alu_decode_stage.sv
// Decode/issue stage ahead of the ALU: turns one RV32I OP/OP-IMM/LUI/AUIPC
// instruction into opcode + operands and holds it in a valid/ready register.
module alu_decode_stage #(
  parameter int VAR_WIDTH = 32,
  parameter int OP_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [VAR_WIDTH-1:0] pc,
  input  logic [VAR_WIDTH-1:0] rs1_data,
  input  logic [VAR_WIDTH-1:0] rs2_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_WIDTH-1:0]  alu_opcode,
  output logic [VAR_WIDTH-1:0] alu_a,
  output logic [VAR_WIDTH-1:0] alu_b,
  output logic [4:0]           rd,
  output logic                 rd_we,
  output logic                 illegal
);

  localparam logic [OP_WIDTH-1:0] ALUADD  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] ALUSUB  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] ALUXOR  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] ALUOR   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] ALUAND  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] ALUSLL  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] ALUSRL  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] ALUSRA  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] ALUSLT  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] ALUSLTU = OP_WIDTH'(9);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  function automatic logic [OP_WIDTH-1:0] f3_to_op(input logic [2:0] f3,
                                                    input logic       sub_sel,
                                                    input logic       sra_sel);
    case (f3)
      3'b000:  f3_to_op = sub_sel ? ALUSUB : ALUADD;
      3'b001:  f3_to_op = ALUSLL;
      3'b010:  f3_to_op = ALUSLT;
      3'b011:  f3_to_op = ALUSLTU;
      3'b100:  f3_to_op = ALUXOR;
      3'b101:  f3_to_op = sra_sel ? ALUSRA : ALUSRL;
      3'b110:  f3_to_op = ALUOR;
      default: f3_to_op = ALUAND;
    endcase
  endfunction

  function automatic logic signed [VAR_WIDTH-1:0] sext12(input logic signed [11:0] imm);
    sext12 = VAR_WIDTH'(imm);
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_shift;

  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  logic                 legal;
  logic [OP_WIDTH-1:0]  opcode_d, opcode_q;
  logic [VAR_WIDTH-1:0] a_d, a_q;
  logic [VAR_WIDTH-1:0] b_d, b_q;
  logic [4:0]           rd_d, rd_q;
  logic                 rd_we_d, rd_we_q;
  logic                 illegal_d, illegal_q;
  logic                 valid_q;
  logic                 accept;

  always_comb begin
    legal    = 1'b0;
    opcode_d = ALUADD;
    a_d      = '0;
    b_d      = '0;
    case (opc)
      OPC_OP: begin
        legal    = (f7 == F7_ZERO) ||
                   ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        opcode_d = f3_to_op(f3, f7[5], f7[5]);
        a_d      = rs1_data;
        // The ALU shifts by all of b, so only the low five bits may pass.
        b_d      = is_shift ? {{(VAR_WIDTH-5){1'b0}}, rs2_data[4:0]} : rs2_data;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)      legal = (f7 == F7_ZERO);
        else if (f3 == 3'b101) legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
        else                   legal = 1'b1;
        opcode_d = f3_to_op(f3, 1'b0, f7[5]);
        a_d      = rs1_data;
        b_d      = is_shift ? {{(VAR_WIDTH-5){1'b0}}, instr[24:20]} : sext12(instr[31:20]);
      end
      OPC_LUI: begin
        legal = 1'b1;
        b_d   = {instr[31:12], {(VAR_WIDTH-20){1'b0}}};
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        a_d   = pc;
        b_d   = {instr[31:12], {(VAR_WIDTH-20){1'b0}}};
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      opcode_d = ALUADD;
      a_d      = '0;
      b_d      = '0;
    end
  end

  assign rd_d      = instr[11:7];
  assign rd_we_d   = legal && (instr[11:7] != 5'd0);
  assign illegal_d = !legal;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Issue register: flush beats accept, accept beats a plain consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (accept) begin
        opcode_q  <= opcode_d;
        a_q       <= a_d;
        b_q       <= b_d;
        rd_q      <= rd_d;
        rd_we_q   <= rd_we_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign alu_opcode = opcode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rd         = rd_q;
  assign rd_we      = rd_we_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vectors, backpressure, flush, reset.
module tb_alu_decode_stage;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, OR = 4'd3, AND = 4'd4,
                         SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [4:0]  rd;
  logic        rd_we, illegal;

  int vectors = 0;
  int miscompares = 0;

  // {out_valid, opcode, a, b, rd, rd_we, illegal}
  logic [75:0] got;
  assign got = {out_valid, alu_opcode, alu_a, alu_b, rd, rd_we, illegal};

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [75:0] exp;
  } vec_t;

  alu_decode_stage #(.VAR_WIDTH(32), .OP_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr = i; pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  task automatic test_reset();
    vectors++;
    if (got !== 76'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: got %h in_ready %b, want 0 in_ready 1", got, in_ready);
    end
  endtask

  task automatic test_op();
    vec_t v[6];
    v[0] = '{32'h002081B3, 32'h0, 32'd5, 32'd7, {1'b1, ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}};
    v[1] = '{32'h402081B3, 32'h0, 32'd5, 32'd7, {1'b1, SUB, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}};
    v[2] = '{32'h002091B3, 32'h0, 32'hF0, 32'h121, {1'b1, SLL, 32'hF0, 32'd1, 5'd3, 1'b1, 1'b0}};
    v[3] = '{32'h0020F1B3, 32'h0, 32'hC, 32'hA, {1'b1, AND, 32'hC, 32'hA, 5'd3, 1'b1, 1'b0}};
    v[4] = '{32'h0020A1B3, 32'h0, 32'h1, 32'h2, {1'b1, SLT, 32'h1, 32'h2, 5'd3, 1'b1, 1'b0}};
    v[5] = '{32'h4020D1B3, 32'h0, 32'h80, 32'hFFFFFFE4, {1'b1, SRA, 32'h80, 32'd4, 5'd3, 1'b1, 1'b0}};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      cyc();
      vectors++;
      if (got !== v[i].exp) begin
        miscompares++;
        $display("FAIL op_decode[%0d]: got %h want %h", i, got, v[i].exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_imm_upper();
    vec_t v[5];
    v[0] = '{32'h40335293, 32'h0, 32'h80000000, 32'h0, {1'b1, SRA, 32'h80000000, 32'd3, 5'd5, 1'b1, 1'b0}};
    v[1] = '{32'h123450B7, 32'h40, 32'h55, 32'h66, {1'b1, ADD, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0}};
    v[2] = '{32'h00001117, 32'h100, 32'h55, 32'h66, {1'b1, ADD, 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0}};
    v[3] = '{32'hFFF00213, 32'h0, 32'h0, 32'h9, {1'b1, ADD, 32'h0, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0}};
    v[4] = '{32'hFFF0B313, 32'h0, 32'hA, 32'h9, {1'b1, SLTU, 32'hA, 32'hFFFFFFFF, 5'd6, 1'b1, 1'b0}};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      cyc();
      vectors++;
      if (got !== v[i].exp) begin
        miscompares++;
        $display("FAIL imm_upper[%0d]: got %h want %h", i, got, v[i].exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal_x0();
    vec_t v[4];
    v[0] = '{32'h00000000, 32'h0, 32'h11, 32'h22, {1'b1, ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1}};
    v[1] = '{32'h00208033, 32'h0, 32'h11, 32'h22, {1'b1, ADD, 32'h11, 32'h22, 5'd0, 1'b0, 1'b0}};
    v[2] = '{32'h202081B3, 32'h0, 32'h11, 32'h22, {1'b1, ADD, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1}};
    v[3] = '{32'h40109093, 32'h0, 32'h11, 32'h22, {1'b1, ADD, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1}};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      cyc();
      vectors++;
      if (got !== v[i].exp) begin
        miscompares++;
        $display("FAIL illegal_x0[%0d]: got %h want %h", i, got, v[i].exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [75:0] ea, eb, ec;
    ea = {1'b1, ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0};
    eb = {1'b1, SUB, 32'd9, 32'd4, 5'd3, 1'b1, 1'b0};
    ec = {1'b1, XOR, 32'hF, 32'h3, 5'd3, 1'b1, 1'b0};
    in_valid = 1'b1; out_ready = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
    cyc();
    out_ready = 1'b0;
    drive(32'h402081B3, 32'h0, 32'd9, 32'd4);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (got !== ea || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %h in_ready %b want %h in_ready 0", i, got, in_ready, ea);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_comb: in_ready %b want 1", in_ready);
    end
    cyc();
    vectors++;
    if (got !== eb) begin
      miscompares++;
      $display("FAIL replace_b: got %h want %h", got, eb);
    end
    drive(32'h0020C1B3, 32'h0, 32'hF, 32'h3);
    cyc();
    vectors++;
    if (got !== ec) begin
      miscompares++;
      $display("FAIL replace_c: got %h want %h", got, ec);
    end
    in_valid = 1'b0;
    cyc();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: out_valid %b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
    cyc();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_accept: out_valid %b want 0", out_valid);
    end
    flush = 1'b0;
    cyc();
    out_ready = 1'b0;
    flush = 1'b1;
    drive(32'h402081B3, 32'h0, 32'd3, 32'd4);
    cyc();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_held: out_valid %b want 0", out_valid);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midstall();
    in_valid = 1'b1; out_ready = 1'b1;
    drive(32'h123450B7, 32'h0, 32'h0, 32'h0);
    cyc();
    out_ready = 1'b0;
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (got !== 76'd0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_async: got %h in_ready %b want 0 in_ready 1", got, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    test_reset();
    #12;
    rst_n = 1'b1;
    cyc();
    test_op();
    test_imm_upper();
    test_illegal_x0();
    test_back_to_back();
    test_flush();
    test_reset_midstall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
